// File: rtl/uart_echo_pkg.sv
// Shared types and constants for the UART echo controller.
package uart_echo_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    WAIT_BUSY = 3'd2,
    WAIT_DONE = 3'd3,
    LF_START  = 3'd4
  } state_t;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

endpackage

// File: rtl/uart_echo_ctrl_if.sv
// Parallel rx/tx handshake between the UART core (master) and the echo controller (slave).
interface uart_echo_if #(
  parameter int DATA_W = 8
);
  logic              rx_done;
  logic [DATA_W-1:0] rx_data;
  logic              tx_busy;
  logic              tx_start;
  logic [DATA_W-1:0] tx_data;

  modport master (output rx_done, rx_data, tx_busy, input  tx_start, tx_data);
  modport slave  (input  rx_done, rx_data, tx_busy, output tx_start, tx_data);
endinterface

// File: rtl/uart_echo_ctrl_sync_fifo.sv
// Synchronous FWFT FIFO; drops pushes while full and flags them with a one-cycle overflow pulse.
module sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] rd_data,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty,
  output logic              overflow
);
  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              do_push, do_pop;

  // Fullness uses the registered count, so a same-cycle pop never rescues a push.
  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign rd_data  = mem_q[rd_ptr_q];
  assign count    = count_q;
  assign overflow = overflow_q;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = push && full;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end
endmodule

// File: rtl/uart_echo_ctrl.sv
// Echo responder: queues received bytes and replays them to the transmitter one at a time.
// Optional UART_ECHO_CRLF_EN: a line feed is appended after every echoed carriage return.
module uart_echo_ctrl
  import uart_echo_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  uart_echo_if.slave       bus,
  output logic [CNT_W-1:0] fifo_count,
  output logic             fifo_full,
  output logic             fifo_empty,
  output logic             overflow
);
  state_t            state_q, state_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  logic [DATA_W-1:0] head;
  logic              pop, start;

  sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (bus.rx_done),
    .push_data (bus.rx_data),
    .pop       (pop),
    .rd_data   (head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .overflow  (overflow)
  );

  assign bus.tx_start = start;
  assign bus.tx_data  = tx_data_q;

  always_comb begin
    state_d   = state_q;
    tx_data_d = tx_data_q;
    pop       = 1'b0;
    start     = 1'b0;
    case (state_q)
      IDLE: if (en && !fifo_empty && !bus.tx_busy) begin
        pop       = 1'b1;
        tx_data_d = head;
        state_d   = START;
      end
      START: begin
        start   = 1'b1;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: if (bus.tx_busy) state_d = WAIT_DONE;
      WAIT_DONE: if (!bus.tx_busy) begin
        state_d = IDLE;
`ifdef UART_ECHO_CRLF_EN
        // tx_data_q still holds the byte just sent, so a finished LF falls back to IDLE.
        if (tx_data_q == DATA_W'(ASCII_CR)) begin
          tx_data_d = DATA_W'(ASCII_LF);
          state_d   = LF_START;
        end
`endif
      end
`ifdef UART_ECHO_CRLF_EN
      LF_START: begin
        start   = 1'b1;
        state_d = WAIT_BUSY;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      tx_data_q <= '0;
    end else begin
      state_q   <= state_d;
      tx_data_q <= tx_data_d;
    end
  end
endmodule

// File: tb/tb_uart_echo_ctrl.sv
// Randomized bench for uart_echo_ctrl against a queue-based echo reference model.
module tb_uart_echo_ctrl;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int CNT_W  = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en  = 1'b0;
  logic [CNT_W-1:0] fifo_count;
  logic fifo_full, fifo_empty, overflow;

  always #5 clk = ~clk;

  uart_echo_if #(.DATA_W(DATA_W)) u_if ();

  uart_echo_ctrl #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .bus        (u_if.slave),
    .fifo_count (fifo_count),
    .fifo_full  (fifo_full),
    .fifo_empty (fifo_empty),
    .overflow   (overflow)
  );

  int n_chk  = 0;
  int n_fail = 0;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] last_tx = '0;
  int ovf_seen = 0;
  int busy_lat = 3;
  int busy_len = 20;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Transmitter model: busy rises busy_lat cycles after tx_start and lasts busy_len cycles.
  int ph, cnt;
  always @(posedge clk) begin
    if (!rst) begin
      u_if.tx_busy <= 1'b0;
      ph  <= 0;
      cnt <= 0;
    end else begin
      case (ph)
        0: if (u_if.tx_start === 1'b1) begin ph <= 1; cnt <= busy_lat - 2; end
        1: if (cnt == 0) begin u_if.tx_busy <= 1'b1; ph <= 2; cnt <= busy_len - 1; end
           else cnt <= cnt - 1;
        default: if (cnt == 0) begin u_if.tx_busy <= 1'b0; ph <= 0; end
                 else cnt <= cnt - 1;
      endcase
    end
  end

  // Monitor: record every transmitted byte and check the handshake rules.
  initial forever begin
    @(negedge clk);
    if (u_if.tx_start === 1'b1) begin
      chk("start_while_busy", 32'(u_if.tx_busy), 32'd0);
      got_q.push_back(u_if.tx_data);
      last_tx = u_if.tx_data;
    end else if (u_if.tx_busy === 1'b1 && rst) begin
      chk("tx_data_hold", 32'(u_if.tx_data), 32'(last_tx));
    end
    if (overflow === 1'b1) ovf_seen++;
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  // Reference: every accepted byte is echoed in order; CR gains a trailing LF when enabled.
  task automatic model_accept(input logic [7:0] b);
    exp_q.push_back(b);
`ifdef UART_ECHO_CRLF_EN
    if (b == 8'h0D) exp_q.push_back(8'h0A);
`endif
  endtask

  task automatic push(input logic [7:0] b, input bit keep);
    u_if.rx_data = b;
    u_if.rx_done = 1'b1;
    tick();
    u_if.rx_done = 1'b0;
    if (keep) model_accept(b);
  endtask

  task automatic drain(input string tag);
    int t = 0;
    while (t < 4000 && !(got_q.size() >= exp_q.size() && fifo_empty === 1'b1
                         && u_if.tx_busy === 1'b0)) begin
      tick();
      t++;
    end
    tick(40);
    chk({tag, "_timeout"}, 32'(t < 4000), 32'd1);
    chk({tag, "_nbytes"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk({tag, "_byte"}, 32'(got_q[i]), 32'(exp_q[i]));
    chk({tag, "_empty"}, 32'(fifo_empty), 32'd1);
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int ovf0, t;
    logic [7:0] b;
    u_if.rx_done = 1'b0;
    u_if.rx_data = '0;
    tick(2);
    chk("rst_empty", 32'(fifo_empty), 32'd1);
    chk("rst_full", 32'(fifo_full), 32'd0);
    chk("rst_count", 32'(fifo_count), 32'd0);
    chk("rst_start", 32'(u_if.tx_start), 32'd0);
    chk("rst_txdata", 32'(u_if.tx_data), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    rst = 1'b1;
    tick(2);

    // Single byte with latency checks.
    en = 1'b1;
    push(8'hA5, 1'b1);
    chk("single_cnt1", 32'(fifo_count), 32'd1);
    chk("single_nempty", 32'(fifo_empty), 32'd0);
    chk("single_nostart", 32'(u_if.tx_start), 32'd0);
    tick();
    chk("single_start", 32'(u_if.tx_start), 32'd1);
    chk("single_data", 32'(u_if.tx_data), 32'hA5);
    chk("single_cnt0", 32'(fifo_count), 32'd0);
    drain("single");

    // Back-to-back burst.
    for (int i = 1; i <= 5; i++) push(8'(i), 1'b1);
    drain("burst");

    // Fill past capacity with draining disabled.
    en   = 1'b0;
    ovf0 = ovf_seen;
    for (int i = 0; i < DEPTH + 1; i++) push(8'($urandom), i < DEPTH);
    chk("full_ovf_pulse", 32'(ovf_seen - ovf0), 32'd1);
    chk("full_flag", 32'(fifo_full), 32'd1);
    chk("full_count", 32'(fifo_count), 32'(DEPTH));
    chk("full_nempty", 32'(fifo_empty), 32'd0);
    tick(5);
    chk("full_ovf_once", 32'(ovf_seen - ovf0), 32'd1);
    en = 1'b1;
    drain("full");

    // Push coinciding with the IDLE pop.
    en = 1'b0;
    push(8'h3C, 1'b1);
    chk("simul_pre", 32'(fifo_count), 32'd1);
    u_if.rx_data = 8'hC3;
    u_if.rx_done = 1'b1;
    en = 1'b1;
    tick();
    u_if.rx_done = 1'b0;
    model_accept(8'hC3);
    chk("simul_count", 32'(fifo_count), 32'd1);
    drain("simul");

    // Reset while a byte is in flight and three are queued.
    busy_lat = 3;
    busy_len = 20;
    for (int i = 0; i < 4; i++) push(8'h10 + 8'(i), 1'b0);
    t = 0;
    while (t < 200 && u_if.tx_busy !== 1'b1) begin tick(); t++; end
    chk("rstmid_busy_seen", 32'(t < 200), 32'd1);
    tick(2);
    #2 rst = 1'b0;
    #1;
    chk("rstmid_start", 32'(u_if.tx_start), 32'd0);
    chk("rstmid_empty", 32'(fifo_empty), 32'd1);
    chk("rstmid_count", 32'(fifo_count), 32'd0);
    tick(2);
    rst = 1'b1;
    got_q.delete();
    exp_q.delete();
    tick(60);
    chk("rstmid_quiet", 32'(got_q.size()), 32'd0);
    push(8'h5A, 1'b1);
    drain("rstmid_after");

    // CR followed by a normal character.
    push(8'h0D, 1'b1);
    push(8'h41, 1'b1);
    drain("crlf");

    // Randomized rounds with varying transmitter timing and en toggling.
    ovf0 = ovf_seen;
    for (int r = 0; r < 12; r++) begin
      busy_lat = int'($urandom_range(2, 5));
      busy_len = int'($urandom_range(1, 20));
      for (int i = 0; i < int'($urandom_range(1, 8)); i++) begin
        b = ($urandom_range(0, 5) == 0) ? 8'h0D : 8'($urandom);
        push(b, 1'b1);
        if ($urandom_range(0, 4) == 0) en = ~en;
        tick(int'($urandom_range(0, 3)));
      end
      en = 1'b1;
      drain("rand");
    end
    chk("rand_no_ovf", 32'(ovf_seen - ovf0), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_echo_ctrl.md
Name: uart_echo_ctrl

Overview:
- User-side counterpart of the UART core's parallel interface.
- Consumes received bytes (rx_done/rx_data) into an internal FIFO, then drains the FIFO back into the transmitter (tx_start/tx_data), honouring tx_busy.
- Sits between the UART core and the rest of the system; it is the echo/loopback responder used for FIFO bring-up and UVM regression.

Parameters:
- DATA_W, 8, byte width on the rx and tx paths.
- DEPTH, 16, number of FIFO entries; must be a power of two, 2 or more.
- CNT_W, $clog2(DEPTH)+1, width of fifo_count.

Ports:
- clk  input  1  system clock, the same clock as the UART core.
- rst  input  1  asynchronous, active-low reset.
- en  input  1  drain enable; when 0, the FIFO still fills but nothing is sent.
- rx_done  input  1  one-cycle pulse from the receiver marking rx_data valid.
- rx_data  input  DATA_W  received byte.
- tx_busy  input  1  transmitter busy.
- tx_start  output  1  one-cycle start pulse to the transmitter.
- tx_data  output  DATA_W  byte to send; held stable from the tx_start pulse until tx_busy falls.
- fifo_count  output  CNT_W  current occupancy.
- fifo_full  output  1  high when fifo_count == DEPTH.
- fifo_empty  output  1  high when fifo_count == 0.
- overflow  output  1  one-cycle pulse when a byte is dropped.

Behaviour:
- Reset (rst=0, asynchronous): pointers and count go to 0, FSM goes to IDLE, tx_start=0, tx_data=0, overflow=0, fifo_empty=1, fifo_full=0. A reset in any state aborts the operation; the FIFO contents are discarded.
- Push: on rx_done=1 with fifo_full=0, write rx_data at wr_ptr. The byte is visible in fifo_count on the next cycle.
- Overflow: rx_done=1 with fifo_full=1 drops the byte and asserts overflow for 1 cycle. Fullness is judged on the pre-cycle count, so a byte is dropped even if a pop happens in the same cycle.
- Pop: only from IDLE. Push and pop in the same cycle leave the count unchanged. Pointers wrap modulo DEPTH.
- FIFO read data is first-word-fall-through (mem[rd_ptr], combinational).
- FSM states:
  - IDLE: if en && !fifo_empty && !tx_busy, pop, register tx_data <= head, go to START.
  - START: tx_start=1 for exactly this cycle, then go to WAIT_BUSY.
  - WAIT_BUSY: wait for tx_busy=1, then go to WAIT_DONE. There is no timeout.
  - WAIT_DONE: wait for tx_busy=0, then go to IDLE (or to LF_START, see Optional Feature).
- Latency: push at cycle N gives fifo_empty=0 at N+1, pop in IDLE at N+1, tx_start at N+2.
- Back-to-back bytes: after tx_busy falls, the FSM spends 1 cycle in IDLE before the next pop. The minimum gap from tx_busy falling to the next tx_start is 2 cycles.
- en deasserted mid-transfer: the current byte completes; no new pop occurs.
- tx_busy already high in IDLE (for example, the transmitter is owned elsewhere): no pop.

Optional Feature:
- Macro: UART_ECHO_CRLF_EN.
- Enabled: when the byte just completed in WAIT_DONE is 8'h0D, the FSM goes to LF_START instead of IDLE.
  - LF_START: tx_data <= 8'h0A, tx_start=1 for 1 cycle, then WAIT_BUSY.
  - After the LF completes, return to IDLE.
  - The inserted LF does not consume a FIFO entry.
- Disabled: LF_START does not exist and 8'h0D is echoed like any other byte.

Decomposition:
- Package uart_echo_pkg:
  - state enum: IDLE, START, WAIT_BUSY, WAIT_DONE, LF_START.
  - constants ASCII_CR=8'h0D and ASCII_LF=8'h0A.
- Sub-module sync_fifo (DATA_W, DEPTH):
  - Provides push/pop, FWFT rd_data, count, full/empty.
  - The drop-on-full rule lives in this module.
- uart_echo_ctrl contains the FSM and tx register.

Test Plan:
- Single byte: rx_done pulse with 8'hA5, tx_busy model rises 3 cycles after tx_start and lasts 20 cycles -> one tx_start, tx_data=8'hA5; fifo_count goes 0 -> 1 -> 0; fifo_empty=1 at the end.
- Burst ordering: push 8'h01..8'h05 back-to-back with en=1 -> five tx_start pulses in order 01..05, exactly one pulse per tx_busy window, never a tx_start while tx_busy=1.
- Full/overflow: en=0, push 17 bytes with DEPTH=16 -> fifo_full=1, fifo_count=16, a single overflow pulse on the 17th. Then set en=1 -> the 16 stored bytes are sent, the 17th never appears.
- Simultaneous push/pop: FIFO holds 1 byte, rx_done arrives in the same cycle as the IDLE pop -> fifo_count stays 1 and both bytes are sent in order.
- Reset mid-operation: assert rst=0 in WAIT_DONE with 3 bytes queued -> immediately tx_start=0, fifo_empty=1, fifo_count=0. After release, no tx_start occurs until a new rx_done arrives.
- CRLF (macro on): push 8'h0D then 8'h41 -> tx sequence 0D, 0A, 41. With the macro off -> 0D, 41.
